// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue / write-back slice:
// op codes, instruction field positions, FSM state encoding.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_LI  = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 7;
  localparam int RT_MSB  = 6;
  localparam int RT_LSB  = 4;
  localparam int IMM_MSB = 9;
  localparam int IMM_W   = 10;

  typedef enum logic {
    IDLE,
    EXEC
  } state_t;

  function automatic logic op_legal(
    input logic [2:0] op
  );
    return (op != 3'd4) && (op != 3'd5);
  endfunction

endpackage

// File: rtl/alu_issue_wb_reg_file.sv
// NREG x DW register file, R0 hardwired to zero.
// Ports: 3 async read ports (rs, rt, dbg), 1 sync write port.
module reg_file #(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] i_ra1,
  output logic [DW-1:0] o_rd1,
  input  logic [AW-1:0] i_ra2,
  output logic [DW-1:0] o_rd2,
  input  logic [AW-1:0] i_ra3,
  output logic [DW-1:0] o_rd3,
  input  logic          i_we,
  input  logic [AW-1:0] i_wa,
  input  logic [DW-1:0] i_wd
);

  logic [DW-1:0] r_mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        r_mem[i] <= '0;
    end else if (i_we && (i_wa != '0)) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_ra1 == '0) ? '0 : r_mem[i_ra1];
  assign o_rd2 = (i_ra2 == '0) ? '0 : r_mem[i_ra2];
  assign o_rd3 = (i_ra3 == '0) ? '0 : r_mem[i_ra3];

endmodule

// File: rtl/yAlu.sv
// Combinational ALU: z = a op b, ex = (z == 0).
// Ports: a, b operands; op code; z result; ex zero indication.
module yAlu #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    op,
  output logic [DW-1:0] z,
  output logic          ex
);

  always_comb begin
    z = '0;
    case (op)
      3'd0: z = a & b;
      3'd1: z = a | b;
      3'd2: z = a + b;
      3'd6: z = a - b;
      3'd7: z = {{(DW-1){1'b0}},
                 ($signed(a) < $signed(b))};
      default: z = '0;
    endcase
  end

  assign ex = (z == '0);

endmodule

// File: rtl/alu_issue_wb.sv
// Issue / write-back stage around yAlu: one instruction in flight.
// Ports: instr valid/ready in, alu_* out, alu_z/ex in, done/illegal/dbg out.
module alu_issue_wb
  import alu_pkg::*;
#(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_op,
  input  logic [DW-1:0] alu_z,
  input  logic          alu_ex,
  output logic          done,
  output logic          zero_flag,
  output logic          illegal,
  input  logic [2:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);

  state_t        r_state;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;
  logic [2:0]    r_op;
  logic [2:0]    r_rd;
  logic          r_done;
  logic          r_zero;
  logic          r_illegal;

  logic [2:0]    w_op;
  logic [2:0]    w_rd;
  logic [2:0]    w_rs;
  logic [2:0]    w_rt;
  logic [DW-1:0] w_imm;
  logic [DW-1:0] w_rs_data;
  logic [DW-1:0] w_rt_data;
  logic          w_legal;
  logic          w_is_li;
  logic          w_we;

  assign w_op    = instr[OP_MSB:OP_LSB];
  assign w_rd    = instr[RD_MSB:RD_LSB];
  assign w_rs    = instr[RS_MSB:RS_LSB];
  assign w_rt    = instr[RT_MSB:RT_LSB];
  assign w_imm   = {{(DW-IMM_W){instr[IMM_MSB]}},
                    instr[IMM_MSB:0]};
  assign w_legal = op_legal(w_op);
  assign w_is_li = (w_op == OP_LI);
  assign w_we    = (r_state == EXEC);

  reg_file #(
    .DW   (DW),
    .NREG (NREG)
  ) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .i_ra1 (w_rs),
    .o_rd1 (w_rs_data),
    .i_ra2 (w_rt),
    .o_rd2 (w_rt_data),
    .i_ra3 (dbg_addr),
    .o_rd3 (dbg_data),
    .i_we  (w_we),
    .i_wa  (r_rd),
    .i_wd  (alu_z)
  );

  // LI reuses the adder: 0 + sign-extended immediate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_rd      <= '0;
      r_done    <= 1'b0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (instr_valid) begin
            if (w_legal) begin
              r_a     <= w_is_li ? '0 : w_rs_data;
              r_b     <= w_is_li ? w_imm : w_rt_data;
              r_op    <= w_is_li ? OP_ADD : w_op;
              r_rd    <= w_rd;
              r_state <= EXEC;
            end else begin
              r_illegal <= 1'b1;
            end
          end
        end
        EXEC: begin
          r_zero  <= alu_ex;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign instr_ready = (r_state == IDLE);
  assign alu_a       = r_a;
  assign alu_b       = r_b;
  assign alu_op      = r_op;
  assign done        = r_done;
  assign zero_flag   = r_zero;
  assign illegal     = r_illegal;

endmodule

// File: tb/tb_alu_issue_wb.sv
// Scoreboard bench for alu_issue_wb with yAlu in the loop.
// Stimulus pushes expected events; a monitor pops them on done/illegal.
module tb_alu_issue_wb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_z;
  logic        alu_ex;
  logic        done;
  logic        zero_flag;
  logic        illegal;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  logic        mon_sel = 1'b0;
  logic [2:0]  mon_addr = '0;
  logic [2:0]  stim_addr = '0;

  assign dbg_addr = mon_sel ? mon_addr : stim_addr;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  alu_issue_wb #(
    .DW   (16),
    .NREG (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_z       (alu_z),
    .alu_ex      (alu_ex),
    .done        (done),
    .zero_flag   (zero_flag),
    .illegal     (illegal),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  yAlu #(.DW(16)) u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .op (alu_op),
    .z  (alu_z),
    .ex (alu_ex)
  );

  typedef struct {
    bit          ill;
    logic [2:0]  rd;
    logic [15:0] val;
    logic        zf;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] req
  );
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [15:0] enc_r(
    input logic [2:0] op, input logic [2:0] rd,
    input logic [2:0] rs, input logic [2:0] rt
  );
    return {op, rd, rs, rt, 4'b0000};
  endfunction

  function automatic logic [15:0] enc_li(
    input logic [2:0] rd, input logic [9:0] imm
  );
    return {3'd3, rd, imm};
  endfunction

  // Waits for ready, handshakes, and records the expected event.
  task automatic issue(
    input  logic [15:0] ins,
    input  bit          ill,
    input  logic [2:0]  rd,
    input  logic [15:0] val,
    input  logic        zf,
    input  bit          hold,
    output int          hcyc
  );
    int w = 0;
    while (!instr_ready && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    hcyc = -1;
    if (!instr_ready) begin
      chk("ready_timeout", {31'd0, instr_ready}, 32'd1);
      return;
    end
    instr_valid = 1'b1;
    instr = ins;
    @(posedge clk); #1;
    hcyc = cyc;
    sbq.push_back('{ill, rd, val, zf, ill ? cyc : cyc + 1});
    if (!hold) instr_valid = 1'b0;
  endtask

  task automatic check_reg(
    input string       name,
    input logic [2:0]  a,
    input logic [15:0] v
  );
    stim_addr = a;
    #1;
    chk(name, {16'd0, dbg_data}, {16'd0, v});
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && (done || illegal)) begin
      if (sbq.size() == 0) begin
        chk("unexpected_event", {30'd0, done, illegal}, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("kind_illegal", {31'd0, illegal}, {31'd0, e.ill});
        chk("kind_done", {31'd0, done}, {31'd0, !e.ill});
        chk("event_cycle", cyc, e.cyc);
        if (done) begin
          mon_sel = 1'b1;
          mon_addr = e.rd;
          #1;
          chk("wb_value", {16'd0, dbg_data}, {16'd0, e.val});
          chk("zero_flag", {31'd0, zero_flag}, {31'd0, e.zf});
          mon_sel = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, h1, h2, h3;

    #12;
    chk("rst_alu_a", {16'd0, alu_a}, 32'd0);
    chk("rst_alu_b", {16'd0, alu_b}, 32'd0);
    chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
    chk("rst_outs", {29'd0, done, zero_flag, illegal}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    check_reg("rst_r1", 3'd1, 16'h0000);

    issue(enc_li(3'd1, 10'd5), 0, 3'd1, 16'h0005, 1'b0, 0, h);
    issue(enc_li(3'd2, 10'h3FD), 0, 3'd2, 16'hFFFD, 1'b0, 0, h);
    issue(enc_r(3'd2, 3'd3, 3'd1, 3'd2), 0, 3'd3, 16'h0002, 1'b0, 0, h);
    issue(enc_r(3'd6, 3'd4, 3'd1, 3'd1), 0, 3'd4, 16'h0000, 1'b1, 0, h);
    issue(enc_r(3'd7, 3'd5, 3'd2, 3'd1), 0, 3'd5, 16'h0001, 1'b0, 0, h);
    issue(enc_r(3'd7, 3'd6, 3'd1, 3'd2), 0, 3'd6, 16'h0000, 1'b1, 0, h);

    issue(enc_li(3'd3, 10'h0F0), 0, 3'd3, 16'h00F0, 1'b0, 0, h);
    issue(enc_li(3'd4, 10'h1FE), 0, 3'd4, 16'h01FE, 1'b0, 0, h);
    issue(enc_r(3'd2, 3'd4, 3'd4, 3'd4), 0, 3'd4, 16'h03FC, 1'b0, 0, h);
    issue(enc_r(3'd2, 3'd4, 3'd4, 3'd4), 0, 3'd4, 16'h07F8, 1'b0, 0, h);
    issue(enc_r(3'd2, 3'd4, 3'd4, 3'd4), 0, 3'd4, 16'h0FF0, 1'b0, 0, h);
    issue(enc_r(3'd0, 3'd7, 3'd3, 3'd4), 0, 3'd7, 16'h00F0, 1'b0, 0, h);
    issue(enc_r(3'd1, 3'd7, 3'd3, 3'd4), 0, 3'd7, 16'h0FF0, 1'b0, 0, h);

    issue(enc_r(3'd4, 3'd1, 3'd2, 3'd3), 1, 3'd1, 16'h0000, 1'b0, 0, h);
    chk("illegal_ready", {31'd0, instr_ready}, 32'd1);
    @(posedge clk); #1;
    check_reg("illegal_r1", 3'd1, 16'h0005);

    issue(enc_r(3'd2, 3'd0, 3'd1, 3'd1), 0, 3'd0, 16'h0000, 1'b0, 1, h1);
    issue(enc_r(3'd6, 3'd6, 3'd2, 3'd1), 0, 3'd6, 16'hFFF8, 1'b0, 1, h2);
    issue(enc_r(3'd1, 3'd5, 3'd0, 3'd1), 0, 3'd5, 16'h0005, 1'b0, 0, h3);
    chk("b2b_gap1", h2 - h1, 32'd2);
    chk("b2b_gap2", h3 - h2, 32'd2);
    @(posedge clk); #1;
    check_reg("r0_zero", 3'd0, 16'h0000);

    @(posedge clk); #1;
    instr_valid = 1'b1;
    instr = enc_r(3'd2, 3'd3, 3'd1, 3'd2);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("exec_alu_a", {16'd0, alu_a}, 32'h0005);
    rst_n = 1'b0;
    #1;
    chk("abort_alu_a", {16'd0, alu_a}, 32'd0);
    chk("abort_alu_b", {16'd0, alu_b}, 32'd0);
    chk("abort_alu_op", {29'd0, alu_op}, 32'd0);
    chk("abort_outs", {29'd0, done, zero_flag, illegal}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready", {31'd0, instr_ready}, 32'd1);
    chk("abort_done", {31'd0, done}, 32'd0);
    check_reg("abort_r3", 3'd3, 16'h0000);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_wb.md
# alu_issue_wb

Register-file-backed issue and write-back stage for the 16-bit datapath: accepts one encoded instruction at a time over a valid/ready handshake, reads two source registers, drives operands and op code into the combinational ALU (`yAlu`), then writes the ALU result and zero indication back. It sits directly around the ALU, feeding `a`, `b` and `op` and consuming `z` and `ex`. Instructions are serialised: at most one in flight, one accepted every 2 cycles.

## Interface
- `DW`, 16, datapath width; operands, results and registers.
- `NREG`, 8, number of registers; fixes the 3-bit register index.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  stage can accept.
- `instr`  in  16  [15:13] op, [12:10] rd, [9:7] rs, [6:4] rt; for LI, [9:0] is a signed immediate.
- `alu_a`  out  DW  ALU operand a, registered.
- `alu_b`  out  DW  ALU operand b, registered.
- `alu_op`  out  3  ALU op code, registered.
- `alu_z`  in  DW  ALU result.
- `alu_ex`  in  1  ALU zero indication.
- `done`  out  1  one-cycle pulse when a write-back completes.
- `zero_flag`  out  1  `alu_ex` captured at the last write-back.
- `illegal`  out  1  one-cycle pulse when an unsupported op is rejected.
- `dbg_addr`  in  3  debug read index.
- `dbg_data`  out  DW  combinational read of register `dbg_addr`.

## Operation
Supported op codes:
- AND=0, OR=1, ADD=2, SUB=6, SLT=7: passed unchanged to the ALU, with `alu_a`=R[rs] and `alu_b`=R[rt].
- LI=3: `alu_op`=2, `alu_a`=0, `alu_b`=sign-extended `instr[9:0]`. The ALU adds, so the result is the immediate.
- Ops 4 and 5 are illegal.

Register and state rules:
- R0 always reads 0. Writes to R0 are discarded, but `zero_flag` and `done` still update.
- FSM states are IDLE and EXEC.
- IDLE: `instr_ready`=1. On handshake with a legal op, register the operands and op and move to EXEC. On handshake with an illegal op, pulse `illegal` next cycle and stay in IDLE; nothing else changes.
- EXEC: `instr_ready`=0. At the end of the cycle, write `alu_z` to R[rd], capture `zero_flag`<=`alu_ex`, set `done`=1 for the next cycle, and return to IDLE.
- `instr_valid` held during EXEC is not accepted; it is taken in the following IDLE cycle.
- Arithmetic is DW-bit two's complement, wrapping; no overflow output. SLT is a signed compare.

Reset values:
- Registers 0, state IDLE.
- `alu_a`, `alu_b`, `alu_op`, `done`, `zero_flag`, `illegal` all 0.
- `instr_ready`=1 once reset is released.
- A reset asserted during EXEC aborts the operation: no register write, no `done`.

## Timing
- Handshake in cycle 0 -> `alu_*` valid in cycle 1 (EXEC).
- Register write, `zero_flag` update and `done` visible in cycle 2, with `instr_ready`=1 again in cycle 2.
- A result written in cycle 2 is readable by an instruction accepted in cycle 2. There are no hazards, because operands are read at acceptance, after the write edge.
- `illegal` pulses in cycle 1.
- `dbg_data` shows the written value from cycle 2.

## Structure
- Shared package `alu_pkg` holds:
  - op localparams `OP_AND`, `OP_OR`, `OP_ADD`, `OP_LI`, `OP_SUB`, `OP_SLT`;
  - the instruction field bit positions;
  - the state enum {IDLE, EXEC}.
- One sub-module, `reg_file`: NREG×DW registers with 2 asynchronous read ports plus the debug port, 1 synchronous write port, R0 forced to 0, asynchronous clear.
- The FSM, immediate extension and op legality check live in `alu_issue_wb`.
- The bench instantiates `yAlu` between `alu_*` and `alu_z`/`alu_ex`.

## Test plan
- LI R1,5 then LI R2,0x3FD -> R1=0x0005, R2=0xFFFD (-3); `done` pulses cycle 2 of each; `zero_flag`=0.
- ADD R3,R1,R2 -> R3=2, `zero_flag`=0; SUB R4,R1,R1 -> R4=0, `zero_flag`=1.
- SLT R5,R2,R1 -> R5=1; SLT R6,R1,R2 -> R6=0 with `zero_flag`=1; AND/OR R7 of 0x00F0 and 0x0FF0 -> 0x00F0 and 0x0FF0.
- Op 4 with rd=1 -> `illegal` pulses one cycle, R1 unchanged, no `done`, `instr_ready` stays 1.
- Back-to-back `instr_valid` held high for 3 instructions -> acceptances 2 cycles apart; ADD R0,R1,R1 -> R0 reads 0, `done` still pulses.
- `rst_n` low during EXEC of ADD R3 -> R3 stays 0, no `done`, all outputs 0, IDLE on release.
